// File: rtl/regfile_operand_reader_pkg.sv
// Shared core definitions for the operand reader: register address width and
// the response entry carried through the response FIFO.
package regfile_operand_reader_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;

    // Entry is sized for the widest configuration; narrower instances leave
    // the upper lanes/bits tied to zero.
    localparam int unsigned MAX_READ_PORTS = 4;
    localparam int unsigned MAX_DATA_WIDTH = 64;
    localparam int unsigned MAX_TAG_WIDTH  = 16;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    typedef struct packed {
        logic [MAX_READ_PORTS-1:0][MAX_DATA_WIDTH-1:0] operands;
        logic [MAX_TAG_WIDTH-1:0]                      tag;
    } rsp_entry_t;

    function automatic logic is_zero_reg(input reg_addr_t addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/regfile_operand_reader_fifo_v3.sv
// Common first-word-fall-through FIFO with synchronous flush; depth need not
// be a power of two.
module fifo_v3 #(
    parameter int unsigned DEPTH = 4,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [PW:0]   count;
    dtype          mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full_o  = count == (PW+1)'(DEPTH);
    assign empty_o = count == '0;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem[rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= data_i;
                wptr      <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_operand_reader.sv
// Reads register operands for a tagged request, applies write-port bypass so
// the operands reflect the accept cycle's writes, and returns them in order.
module regfile_operand_reader
    import regfile_operand_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NR_READ_PORTS  = 2,
    parameter int unsigned NR_WRITE_PORTS = 1,
    parameter bit          SYNC_READ      = 1'b0,
    parameter bit          ZERO_REG_ZERO  = 1'b0,
    parameter int unsigned TAG_WIDTH      = 4
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic                                           flush_i,
    input  logic                                           req_valid_i,
    output logic                                           req_ready_o,
    input  logic [NR_READ_PORTS-1:0][REG_ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [TAG_WIDTH-1:0]                           req_tag_i,
    output logic [NR_READ_PORTS-1:0][REG_ADDR_WIDTH-1:0]   raddr_o,
    input  logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]       rdata_i,
    input  logic [NR_WRITE_PORTS-1:0][REG_ADDR_WIDTH-1:0]  waddr_i,
    input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]      wdata_i,
    input  logic [NR_WRITE_PORTS-1:0]                      we_i,
    output logic                                           rsp_valid_o,
    input  logic                                           rsp_ready_i,
    output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]       rsp_data_o,
    output logic [TAG_WIDTH-1:0]                           rsp_tag_o
);

    localparam int unsigned LAT   = SYNC_READ ? 2 : 1;
    localparam int unsigned DEPTH = LAT + 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]                           cnt;
    logic                                       accept;
    logic                                       rsp_hs;
    logic [NR_READ_PORTS-1:0]                   byp_hit;
    logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]   byp_data;
    logic [NR_READ_PORTS-1:0]                   op_zero;
    logic                                       push;
    rsp_entry_t                                 entry_in;
    rsp_entry_t                                 entry_out;
    logic                                       fifo_empty;
    logic                                       unused_full;
    logic                                       unused_entry;

    assign raddr_o     = req_addr_i;
    assign req_ready_o = (cnt < CNT_W'(DEPTH)) & ~flush_i;
    assign accept      = req_valid_i & req_ready_o;
    assign rsp_valid_o = ~fifo_empty;
    assign rsp_hs      = rsp_valid_o & rsp_ready_i;

    // Later write ports win; x0 writes never bypass.
    always_comb begin
        byp_hit  = '0;
        byp_data = '0;
        op_zero  = '0;
        for (int unsigned r = 0; r < NR_READ_PORTS; r++) begin
            op_zero[r] = ZERO_REG_ZERO & is_zero_reg(req_addr_i[r]);
            for (int unsigned w = 0; w < NR_WRITE_PORTS; w++) begin
                if (we_i[w] && !is_zero_reg(waddr_i[w]) && waddr_i[w] == req_addr_i[r]) begin
                    byp_hit[r]  = 1'b1;
                    byp_data[r] = wdata_i[w];
                end
            end
        end
    end

    if (!SYNC_READ) begin : g_async_read
        assign push = accept;

        always_comb begin
            entry_in = '0;
            entry_in.tag[TAG_WIDTH-1:0] = req_tag_i;
            for (int unsigned r = 0; r < NR_READ_PORTS; r++) begin
                if (op_zero[r]) begin
                    entry_in.operands[r][DATA_WIDTH-1:0] = '0;
                end else if (byp_hit[r]) begin
                    entry_in.operands[r][DATA_WIDTH-1:0] = byp_data[r];
                end else begin
                    entry_in.operands[r][DATA_WIDTH-1:0] = rdata_i[r];
                end
            end
        end
    end else begin : g_sync_read
        // Accept-cycle bypass is captured here and merged with the read data
        // returning one cycle later; that later cycle's writes are ignored.
        logic                                     s1_valid;
        logic [TAG_WIDTH-1:0]                     s1_tag;
        logic [NR_READ_PORTS-1:0]                 s1_hit;
        logic [NR_READ_PORTS-1:0]                 s1_zero;
        logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] s1_data;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s1_valid <= 1'b0;
                s1_tag   <= '0;
                s1_hit   <= '0;
                s1_zero  <= '0;
                s1_data  <= '0;
            end else begin
                s1_valid <= accept;
                if (accept) begin
                    s1_tag  <= req_tag_i;
                    s1_hit  <= byp_hit;
                    s1_zero <= op_zero;
                    s1_data <= byp_data;
                end
            end
        end

        assign push = s1_valid;

        always_comb begin
            entry_in = '0;
            entry_in.tag[TAG_WIDTH-1:0] = s1_tag;
            for (int unsigned r = 0; r < NR_READ_PORTS; r++) begin
                if (s1_zero[r]) begin
                    entry_in.operands[r][DATA_WIDTH-1:0] = '0;
                end else if (s1_hit[r]) begin
                    entry_in.operands[r][DATA_WIDTH-1:0] = s1_data[r];
                end else begin
                    entry_in.operands[r][DATA_WIDTH-1:0] = rdata_i[r];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (flush_i) begin
            cnt <= '0;
        end else if (accept && !rsp_hs) begin
            cnt <= cnt + CNT_W'(1);
        end else if (!accept && rsp_hs) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    fifo_v3 #(
        .DEPTH (DEPTH),
        .dtype (rsp_entry_t)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .full_o  (unused_full),
        .empty_o (fifo_empty),
        .data_i  (entry_in),
        .push_i  (push),
        .data_o  (entry_out),
        .pop_i   (rsp_ready_i)
    );

    assign unused_entry = ^entry_out;

    // Outputs read as zero whenever no response is presented.
    always_comb begin
        rsp_data_o = '0;
        rsp_tag_o  = '0;
        if (rsp_valid_o) begin
            for (int unsigned r = 0; r < NR_READ_PORTS; r++) begin
                rsp_data_o[r] = entry_out.operands[r][DATA_WIDTH-1:0];
            end
            rsp_tag_o = entry_out.tag[TAG_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_regfile_operand_reader.sv
// Drives an async-read and a sync-read instance with shared stimulus and checks
// both against a queue-based model of acceptance order and response timing.
module tb_regfile_operand_reader;

    localparam int NR = 2;
    localparam int NW = 2;
    localparam int TW = 4;

    typedef struct {
        int                 rdy;
        logic [NR-1:0][31:0] d;
        logic [TW-1:0]      tag;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 flush = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 rsp_ready = 1'b0;
    logic [NR-1:0][4:0]   req_addr = '0;
    logic [TW-1:0]        req_tag = '0;
    logic [NW-1:0][4:0]   waddr = '0;
    logic [NW-1:0][31:0]  wdata = '0;
    logic [NW-1:0]        we = '0;
    logic [31:0]          x0_val = '0;
    logic [31:0]          regs [32] = '{default: '0};

    logic                 req_ready [2];
    logic                 rsp_valid [2];
    logic [NR-1:0][4:0]   raddr [2];
    logic [NR-1:0][31:0]  rsp_data [2];
    logic [TW-1:0]        rsp_tag [2];
    logic [NR-1:0][31:0]  rdata_a;
    logic [NR-1:0][31:0]  rdata_s;

    int n_chk = 0;
    int n_pass = 0;

    int                  lat_r [2];
    logic [NR-1:0][31:0] dat_r [2];
    logic [TW-1:0]       tag_r [2];

    always #5 clk = ~clk;

    regfile_operand_reader #(
        .DATA_WIDTH(32), .NR_READ_PORTS(NR), .NR_WRITE_PORTS(NW),
        .SYNC_READ(1'b0), .ZERO_REG_ZERO(1'b0), .TAG_WIDTH(TW)
    ) dut_async (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready[0]),
        .req_addr_i(req_addr), .req_tag_i(req_tag), .raddr_o(raddr[0]),
        .rdata_i(rdata_a), .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data[0]), .rsp_tag_o(rsp_tag[0])
    );

    regfile_operand_reader #(
        .DATA_WIDTH(32), .NR_READ_PORTS(NR), .NR_WRITE_PORTS(NW),
        .SYNC_READ(1'b1), .ZERO_REG_ZERO(1'b1), .TAG_WIDTH(TW)
    ) dut_sync (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready[1]),
        .req_addr_i(req_addr), .req_tag_i(req_tag), .raddr_o(raddr[1]),
        .rdata_i(rdata_s), .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data[1]), .rsp_tag_o(rsp_tag[1])
    );

    // Register file: combinational read for the async instance, registered
    // read (old data on read-during-write) for the sync instance.
    always_comb begin
        for (int r = 0; r < NR; r++) begin
            rdata_a[r] = (raddr[0][r] == 5'd0) ? x0_val : regs[raddr[0][r]];
        end
    end

    always @(posedge clk) begin
        for (int r = 0; r < NR; r++) begin
            rdata_s[r] <= (raddr[1][r] == 5'd0) ? x0_val : regs[raddr[1][r]];
        end
        for (int w = 0; w < NW; w++) begin
            if (we[w] && waddr[w] != 5'd0) regs[waddr[w]] <= wdata[w];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Architectural value of a register once the current cycle's writes land.
    function automatic logic [31:0] snap(input logic [4:0] a, input bit zero);
        logic [31:0] v;
        if (zero && a == 5'd0) return '0;
        v = (a == 5'd0) ? x0_val : regs[a];
        if (a != 5'd0) begin
            for (int w = 0; w < NW; w++) begin
                if (we[w] && waddr[w] == a) v = wdata[w];
            end
        end
        return v;
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_model
        localparam int LAT   = (d == 0) ? 1 : 2;
        localparam int DEPTH = LAT + 1;
        localparam bit ZERO  = (d == 1);
        exp_t q[$];
        int   cyc = 0;

        always @(negedge clk) begin : cmp
            exp_t e;
            logic ev;
            logic er;
            cyc++;
            if (!rst_n) begin
                q.delete();
                chk($sformatf("reset_valid%0d", d), rsp_valid[d], 0);
                chk($sformatf("reset_ready%0d", d), req_ready[d], 1);
                chk($sformatf("reset_data%0d", d), rsp_data[d], 0);
                chk($sformatf("reset_tag%0d", d), rsp_tag[d], 0);
            end else begin
                ev = (q.size() > 0) && (q[0].rdy <= cyc);
                er = (q.size() < DEPTH) && !flush;
                chk($sformatf("rsp_valid%0d", d), rsp_valid[d], ev);
                chk($sformatf("req_ready%0d", d), req_ready[d], er);
                chk($sformatf("raddr%0d", d), raddr[d], req_addr);
                if (ev) begin
                    chk($sformatf("rsp_data%0d", d), rsp_data[d], q[0].d);
                    chk($sformatf("rsp_tag%0d", d), rsp_tag[d], q[0].tag);
                end
                if (flush) begin
                    q.delete();
                end else begin
                    if (ev && rsp_ready) void'(q.pop_front());
                    if (req_valid && er) begin
                        for (int r = 0; r < NR; r++) e.d[r] = snap(req_addr[r], ZERO);
                        e.tag = req_tag;
                        e.rdy = cyc + LAT;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single_req(input logic [4:0] a0, input logic [4:0] a1, input logic [3:0] t,
                              input logic [1:0] wen, input logic [4:0] wa0, input logic [4:0] wa1,
                              input logic [31:0] wd0, input logic [31:0] wd1);
        logic got [2];
        req_valid = 1'b1; req_addr[0] = a0; req_addr[1] = a1; req_tag = t;
        we = wen; waddr[0] = wa0; waddr[1] = wa1; wdata[0] = wd0; wdata[1] = wd1;
        rsp_ready = 1'b1;
        for (int d = 0; d < 2; d++) begin
            got[d] = 1'b0; lat_r[d] = 99; dat_r[d] = '0; tag_r[d] = '0;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk($sformatf("single_accept%0d", d), req_ready[d], 1);
        step();
        req_valid = 1'b0; we = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!got[d] && rsp_valid[d]) begin
                    got[d] = 1'b1; lat_r[d] = k; dat_r[d] = rsp_data[d]; tag_r[d] = rsp_tag[d];
                end
            end
        end
        step();
    endtask

    initial begin
        int nacc [2];
        int nrsp [2];
        int frsp [2];
        int lrsp [2];
        logic [TW-1:0] tags1 [4];

        repeat (3) @(negedge clk);
        step();
        rst_n = 1'b1;
        step();

        // x5 <= 0x11, then request {x5, x0} with tag 3
        we = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'h11;
        step();
        we = '0;
        single_req(5'd5, 5'd0, 4'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        chk("x5_lat_async", lat_r[0], 1);
        chk("x5_lat_sync", lat_r[1], 2);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("x5_op0_%0d", d), dat_r[d][0], 32'h11);
            chk($sformatf("x5_op1_%0d", d), dat_r[d][1], 32'h0);
            chk($sformatf("x5_tag_%0d", d), tag_r[d], 4'd3);
        end

        // both write ports hit x7 in the accept cycle: port 1 wins
        single_req(5'd7, 5'd5, 4'd5, 2'b11, 5'd7, 5'd7, 32'hA, 32'hB);
        chk("x7_lat_sync", lat_r[1], 2);
        for (int d = 0; d < 2; d++) chk($sformatf("x7_bypass_%0d", d), dat_r[d][0], 32'hB);

        // x0 write is never bypassed; zeroing instance returns 0
        x0_val = 32'h55;
        single_req(5'd0, 5'd0, 4'd6, 2'b01, 5'd0, 5'd0, 32'hFF, 32'h0);
        chk("x0_async", dat_r[0][0], 32'h55);
        chk("x0_sync_zero", dat_r[1][0], 32'h0);
        chk("x0_sync_zero1", dat_r[1][1], 32'h0);

        // fill with rsp_ready low: exactly DEPTH accepted
        rsp_ready = 1'b0;
        nacc = '{0, 0};
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_tag = 4'(8 + i);
            req_addr[0] = 5'($urandom_range(0, 7)); req_addr[1] = 5'($urandom_range(0, 7));
            @(negedge clk);
            for (int d = 0; d < 2; d++) if (req_ready[d]) nacc[d]++;
            step();
        end
        req_valid = 1'b0;
        chk("fill_async", nacc[0], 2);
        chk("fill_sync", nacc[1], 3);
        rsp_ready = 1'b1;
        nrsp = '{0, 0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid[1] && nrsp[1] < 4) begin
                tags1[nrsp[1]] = rsp_tag[1];
                nrsp[1]++;
            end
        end
        step();
        chk("drain_count_sync", nrsp[1], 3);
        chk("drain_tag0", tags1[0], 4'd8);
        chk("drain_tag1", tags1[1], 4'd9);
        chk("drain_tag2", tags1[2], 4'd10);

        // three outstanding, then a one-cycle flush
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_tag = 4'(1 + i);
            step();
        end
        req_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk($sformatf("flush_ready%0d", d), req_ready[d], 0);
        step();
        flush = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("post_flush_valid%0d", d), rsp_valid[d], 0);
            chk($sformatf("post_flush_ready%0d", d), req_ready[d], 1);
        end
        step();
        single_req(5'd5, 5'd7, 4'd12, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        chk("flush_lat_async", lat_r[0], 1);
        chk("flush_lat_sync", lat_r[1], 2);
        chk("flush_tag", tag_r[1], 4'd12);

        // eight back-to-back requests with rsp_ready held high
        rsp_ready = 1'b1;
        nacc = '{0, 0}; nrsp = '{0, 0}; frsp = '{-1, -1}; lrsp = '{-1, -1};
        for (int k = 0; k < 14; k++) begin
            req_valid = (k < 8);
            req_tag = 4'(k);
            req_addr[0] = 5'($urandom_range(0, 7)); req_addr[1] = 5'($urandom_range(0, 7));
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (req_valid && req_ready[d]) nacc[d]++;
                if (rsp_valid[d]) begin
                    if (frsp[d] < 0) frsp[d] = k;
                    lrsp[d] = k;
                    nrsp[d]++;
                end
            end
            step();
        end
        req_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("b2b_acc%0d", d), nacc[d], 8);
            chk($sformatf("b2b_rsp%0d", d), nrsp[d], 8);
            chk($sformatf("b2b_span%0d", d), lrsp[d] - frsp[d], 7);
        end
        chk("b2b_first_async", frsp[0], 1);
        chk("b2b_first_sync", frsp[1], 2);

        // reset in the middle of outstanding traffic
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        step();
        step();
        req_valid = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk($sformatf("post_reset_valid%0d", d), rsp_valid[d], 0);
        step();

        // randomized traffic
        repeat (600) begin
            req_valid = ($urandom_range(0, 99) < 70);
            req_addr[0] = 5'($urandom_range(0, 7));
            req_addr[1] = 5'($urandom_range(0, 7));
            req_tag = 4'($urandom);
            for (int w = 0; w < NW; w++) begin
                we[w] = $urandom_range(0, 1) == 1;
                waddr[w] = 5'($urandom_range(0, 7));
                wdata[w] = $urandom;
            end
            rsp_ready = ($urandom_range(0, 99) < 75);
            flush = ($urandom_range(0, 99) < 3);
            step();
        end
        req_valid = 1'b0; we = '0; flush = 1'b0; rsp_ready = 1'b1;
        repeat (8) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
